// File: rtl/stream_decimating_averager.sv
// Multichannel stream decimator: averages groups of 2^LOG2_RATIO signed samples
// per channel and emits one registered result per completed group.
module stream_decimating_averager #(
   parameter int DATA_WIDTH = 16,
   parameter int N_CHANNELS = 2,
   parameter int LOG2_RATIO = 2,
   parameter int DEST_WIDTH = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [DEST_WIDTH-1:0] in_dest,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [DEST_WIDTH-1:0] out_dest,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  dropped
);

   localparam int ACC_W = DATA_WIDTH + LOG2_RATIO;
   localparam int CNT_W = (LOG2_RATIO > 0) ? LOG2_RATIO : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_RATIO) - 1);

   logic signed [ACC_W-1:0] acc_q [N_CHANNELS];
   logic signed [ACC_W-1:0] acc_d [N_CHANNELS];
   logic [CNT_W-1:0]        cnt_q [N_CHANNELS];
   logic [CNT_W-1:0]        cnt_d [N_CHANNELS];

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [DEST_WIDTH-1:0] out_dest_q, out_dest_d;
   logic                  dropped_q, dropped_d;
   logic                  ready_en_q;

   logic [31:0]             dest_ext_s;
   logic                    in_range_s;
   logic                    accept_s;
   logic                    last_s;
   logic                    complete_s;
   logic signed [ACC_W-1:0] sel_acc_s;
   logic [CNT_W-1:0]        sel_cnt_s;
   logic signed [ACC_W-1:0] sext_s;
   logic signed [ACC_W-1:0] sum_s;
   logic [DATA_WIDTH-1:0]   avg_s;

   // ready_en_q keeps in_ready low until the first edge after reset release
   assign in_ready  = ready_en_q && (!out_valid_q || out_ready);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_dest  = out_dest_q;
   assign dropped   = dropped_q;

   // Select the addressed channel and form the running sum and group average
   always_comb begin
      dest_ext_s = 32'(in_dest);
      in_range_s = dest_ext_s < 32'(N_CHANNELS);
      accept_s   = in_valid && in_ready;
      sel_acc_s  = '0;
      sel_cnt_s  = '0;
      for (int c = 0; c < N_CHANNELS; c++) begin
         sel_acc_s = (dest_ext_s == 32'(c)) ? acc_q[c] : sel_acc_s;
         sel_cnt_s = (dest_ext_s == 32'(c)) ? cnt_q[c] : sel_cnt_s;
      end
      sext_s     = ACC_W'($signed(in_data));
      sum_s      = sel_acc_s + sext_s;
      avg_s      = DATA_WIDTH'(sum_s >>> LOG2_RATIO);
      last_s     = (sel_cnt_s == CNT_LAST);
      complete_s = accept_s && in_range_s && !clear && last_s;
   end

   // Per-channel accumulator and counter next state
   always_comb begin
      for (int c = 0; c < N_CHANNELS; c++) begin
         acc_d[c] = acc_q[c];
         cnt_d[c] = cnt_q[c];
         if (clear) begin
            acc_d[c] = '0;
            cnt_d[c] = '0;
         end else if (accept_s && in_range_s && (dest_ext_s == 32'(c))) begin
            if (last_s) begin
               acc_d[c] = '0;
               cnt_d[c] = '0;
            end else begin
               acc_d[c] = sum_s;
               cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
         end else begin
            acc_d[c] = acc_q[c];
            cnt_d[c] = cnt_q[c];
         end
      end
   end

   // Output register: a completion refills it even while it is being drained
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_dest_d  = out_dest_q;
      if (complete_s) begin
         out_valid_d = 1'b1;
         out_data_d  = avg_s;
         out_dest_d  = in_dest;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      dropped_d = accept_s && !in_range_s && !clear;
   end

   // State registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < N_CHANNELS; c++) begin
            acc_q[c] <= '0;
            cnt_q[c] <= '0;
         end
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_dest_q  <= '0;
         dropped_q   <= 1'b0;
         ready_en_q  <= 1'b0;
      end else begin
         for (int c = 0; c < N_CHANNELS; c++) begin
            acc_q[c] <= acc_d[c];
            cnt_q[c] <= cnt_d[c];
         end
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_dest_q  <= out_dest_d;
         dropped_q   <= dropped_d;
         ready_en_q  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_decimating_averager.sv
// Bench for stream_decimating_averager: directed steps then random traffic,
// compared cycle by cycle with an arithmetic reference model.
module tb_stream_decimating_averager;

   localparam int DW    = 16;
   localparam int NC    = 2;
   localparam int L2    = 2;
   localparam int DSTW  = 2;
   localparam int RATIO = 4;

   logic            clock;
   logic            reset;
   logic            clear;
   logic [DW-1:0]   in_data;
   logic [DSTW-1:0] in_dest;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   out_data;
   logic [DSTW-1:0] out_dest;
   logic            out_valid;
   logic            out_ready;
   logic            dropped;

   int n_checks;
   int n_pass;
   int n_fail;

   // reference model state
   int              sum_m [NC];
   int              cnt_m [NC];
   logic            ev;
   logic [DW-1:0]   ed;
   logic [DSTW-1:0] edst;
   logic            edrop;
   logic            rdy_m;

   stream_decimating_averager #(
      .DATA_WIDTH(DW),
      .N_CHANNELS(NC),
      .LOG2_RATIO(L2),
      .DEST_WIDTH(DSTW)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear),
      .in_data  (in_data),
      .in_dest  (in_dest),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_dest (out_dest),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .dropped  (dropped)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // average rounded toward minus infinity
   function automatic int floor_avg(input int s);
      int q;
      q = s / RATIO;
      if ((s % RATIO) != 0 && s < 0) q = q - 1;
      return q;
   endfunction

   task automatic model_zero_channels();
      for (int c = 0; c < NC; c++) begin
         sum_m[c] = 0;
         cnt_m[c] = 0;
      end
   endtask

   task automatic check_outputs();
      check("out_valid", 32'(out_valid), 32'(ev));
      check("out_data", 32'(out_data), 32'(ed));
      check("out_dest", 32'(out_dest), 32'(edst));
      check("dropped", 32'(dropped), 32'(edrop));
   endtask

   task automatic tick(input logic v, input int d, input int dst, input logic rdy, input logic clr);
      logic exp_ir;
      logic acc_m;
      logic nv;
      in_valid  = v;
      in_data   = DW'(d);
      in_dest   = DSTW'(dst);
      out_ready = rdy;
      clear     = clr;
      @(negedge clock);
      exp_ir = rdy_m && (!ev || rdy);
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      acc_m = v && exp_ir;
      nv    = ev;
      if (ev && rdy) nv = 1'b0;
      edrop = 1'b0;
      if (clr) begin
         model_zero_channels();
      end else if (acc_m) begin
         if (dst >= NC) begin
            edrop = 1'b1;
         end else begin
            sum_m[dst] = sum_m[dst] + d;
            cnt_m[dst] = cnt_m[dst] + 1;
            if (cnt_m[dst] == RATIO) begin
               nv   = 1'b1;
               ed   = DW'(floor_avg(sum_m[dst]));
               edst = DSTW'(dst);
               sum_m[dst] = 0;
               cnt_m[dst] = 0;
            end
         end
      end
      ev = nv;
      @(posedge clock);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;
      @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      model_zero_channels();
      ev    = 1'b0;
      ed    = '0;
      edst  = '0;
      edrop = 1'b0;
      rdy_m = 1'b0;
      check_outputs();
      check("in_ready_rst", 32'(in_ready), 32'(1'b0));
      @(negedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("in_ready_rel", 32'(in_ready), 32'(1'b0));
      @(posedge clock);
      #1;
      rdy_m = 1'b1;
      check("in_ready_up", 32'(in_ready), 32'(1'b1));
      check_outputs();
   endtask

   initial begin
      logic signed [DW-1:0] r16;
      n_checks  = 0;
      n_pass    = 0;
      n_fail    = 0;
      reset     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_dest   = '0;
      out_ready = 1'b1;
      do_reset();

      // basic group on channel 0
      tick(1'b1, 10, 0, 1'b1, 1'b0);
      tick(1'b1, 20, 0, 1'b1, 1'b0);
      tick(1'b1, 30, 0, 1'b1, 1'b0);
      tick(1'b1, 40, 0, 1'b1, 1'b0);
      check("basic_valid", 32'(out_valid), 32'(1'b1));
      check("basic_avg", 32'(out_data), 32'(16'd25));
      tick(1'b0, 0, 0, 1'b1, 1'b0);
      check("basic_drop_valid", 32'(out_valid), 32'(1'b0));

      // negative rounding and full scale
      tick(1'b1, -1, 1, 1'b1, 1'b0);
      tick(1'b1, -2, 1, 1'b1, 1'b0);
      tick(1'b1, -2, 1, 1'b1, 1'b0);
      tick(1'b1, -2, 1, 1'b1, 1'b0);
      check("neg_round", 32'(out_data), 32'(16'hFFFE));
      check("neg_dest", 32'(out_dest), 32'(2'd1));
      for (int i = 0; i < 4; i++) tick(1'b1, 32767, 0, 1'b1, 1'b0);
      check("full_pos", 32'(out_data), 32'(16'h7FFF));
      for (int i = 0; i < 4; i++) tick(1'b1, -32768, 1, 1'b1, 1'b0);
      check("full_neg", 32'(out_data), 32'(16'h8000));

      // interleaved channels
      tick(1'b1, 1, 0, 1'b1, 1'b0);
      tick(1'b1, 100, 1, 1'b1, 1'b0);
      tick(1'b1, 3, 0, 1'b1, 1'b0);
      tick(1'b1, 300, 1, 1'b1, 1'b0);
      tick(1'b1, 5, 0, 1'b1, 1'b0);
      tick(1'b1, 500, 1, 1'b1, 1'b0);
      tick(1'b1, 7, 0, 1'b1, 1'b0);
      check("ilv_ch0", 32'(out_data), 32'(16'd4));
      check("ilv_ch0_dest", 32'(out_dest), 32'(2'd0));
      tick(1'b1, 700, 1, 1'b1, 1'b0);
      check("ilv_ch1", 32'(out_data), 32'(16'd400));
      check("ilv_ch1_dest", 32'(out_dest), 32'(2'd1));
      tick(1'b0, 0, 0, 1'b1, 1'b0);

      // backpressure hold then sustained throughput
      tick(1'b1, 100, 0, 1'b0, 1'b0);
      tick(1'b1, 100, 0, 1'b0, 1'b0);
      tick(1'b1, 100, 0, 1'b0, 1'b0);
      tick(1'b1, 104, 0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 7, 0, 1'b0, 1'b0);
         check("bp_hold", 32'(out_data), 32'(16'd101));
      end
      for (int i = 0; i < 8; i++) tick(1'b1, i * 4, 0, 1'b1, 1'b0);
      check("bp_sustain", 32'(out_data), 32'(16'd22));
      tick(1'b0, 0, 0, 1'b1, 1'b0);

      // out-of-range dest
      tick(1'b1, 10, 0, 1'b1, 1'b0);
      tick(1'b1, 10, 0, 1'b1, 1'b0);
      tick(1'b1, 1000, 3, 1'b1, 1'b0);
      check("drop_pulse", 32'(dropped), 32'(1'b1));
      tick(1'b0, 0, 0, 1'b1, 1'b0);
      check("drop_end", 32'(dropped), 32'(1'b0));
      tick(1'b1, 10, 0, 1'b1, 1'b0);
      tick(1'b1, 10, 0, 1'b1, 1'b0);
      check("drop_unchanged", 32'(out_data), 32'(16'd10));

      // clear discards partial group
      tick(1'b1, 5, 0, 1'b1, 1'b0);
      tick(1'b1, 5, 0, 1'b1, 1'b0);
      tick(1'b1, 999, 0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) tick(1'b1, 8, 0, 1'b1, 1'b0);
      check("clear_avg", 32'(out_data), 32'(16'd8));

      // reset mid-group
      tick(1'b1, 7, 0, 1'b1, 1'b0);
      tick(1'b1, 7, 0, 1'b1, 1'b0);
      tick(1'b1, 7, 0, 1'b1, 1'b0);
      do_reset();
      tick(1'b1, 40, 0, 1'b1, 1'b0);
      tick(1'b1, 50, 0, 1'b1, 1'b0);
      tick(1'b1, 60, 0, 1'b1, 1'b0);
      tick(1'b1, 50, 0, 1'b1, 1'b0);
      check("post_reset_avg", 32'(out_data), 32'(16'd50));

      // random traffic
      for (int i = 0; i < 400; i++) begin
         r16 = DW'($urandom);
         tick($urandom_range(0, 3) != 0, int'(r16), int'($urandom_range(0, 3)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
